alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single instance of the team's 8-bit `alu` among N_REQ requesters. Each requester submits an operation over a valid/ready handshake. The block latches the granted operands, executes the operation in the ALU, and returns the result tagged with the requester index over a valid/ready response channel. It sits between the multiple ALU clients and the shared combinational ALU datapath.

---
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the ALU clients and the shared ALU
// arbiter. Requester i owns bit i of the scalar vectors, bits [8i+7:8i]
// of the operand vectors and bits [4i+3:4i] of the op-code vector.
interface alu_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_x;
  logic [8*N_REQ-1:0] req_y;
  logic [4*N_REQ-1:0] req_op;
  logic [N_REQ-1:0]   req_cin;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [7:0]         rsp_data;
  logic               rsp_carry;
  logic [15:0]        op_count;

  // Client side: issues operations and consumes results.
  modport master (
    output req_valid, req_x, req_y, req_op, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, op_count
  );

  // Arbiter side: grants one client at a time and returns its result.
  modport slave (
    input  req_valid, req_x, req_y, req_op, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational 8-bit ALU
// among N_REQ clients. One operation is in flight at a time:
// IDLE (grant) -> EXEC (compute, register result) -> RESP (hold result
// until the consumer takes it).
module alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;

  // Arbitration
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] grant_id;
  logic           grant_found;
  logic           accept;
  logic           rsp_fire;

  // Latched operation of the granted client
  logic [7:0]     x_q;
  logic [7:0]     y_q;
  logic [3:0]     op_q;
  logic           cin_q;
  logic [IDW-1:0] id_q;

  // ALU outputs
  logic [7:0]     alu_res;
  logic           alu_carry;

  // Response registers
  logic [7:0]     rsp_data_q;
  logic           rsp_carry_q;
  logic [IDW-1:0] rsp_id_q;
  logic [15:0]    op_count_q;

  // Round-robin search: first valid requester after the last one granted.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % N_REQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    accept        = 1'b0;
    rsp_fire      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          bus.req_ready = N_REQ'(1) << grant_id;
          accept        = 1'b1;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shared ALU; op[3] is a don't-care, carry only on add/sub.
  always_comb begin
    logic [8:0] sum;
    logic [7:0] neg_y;
    neg_y     = ~y_q + 8'd1;
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (op_q[2:0])
      3'b000: begin
        sum       = {1'b0, x_q} + {1'b0, y_q} + {8'd0, cin_q};
        alu_res   = sum[7:0];
        alu_carry = sum[8];
      end
      3'b001: begin
        sum       = {1'b0, x_q} + {1'b0, neg_y} + {8'd0, cin_q};
        alu_res   = sum[7:0];
        alu_carry = sum[8];
      end
      3'b010:  alu_res = x_q & y_q;
      3'b011:  alu_res = x_q | y_q;
      3'b100:  alu_res = ~(x_q & y_q);
      3'b101:  alu_res = x_q ^ y_q;
      3'b110:  alu_res = ~(x_q | y_q);
      default: alu_res = ~x_q;
    endcase
  end

  // FSM state register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples the values from before the edge.
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant_id;
      end
    end
  end

  // Capture the granted client's operation on the request handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand registers are reset as well; they are few, and this keeps
    // the ALU inputs free of X after reset.
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      op_q  <= '0;
      cin_q <= 1'b0;
      id_q  <= '0;
    end else if (accept) begin
      x_q   <= bus.req_x[8*grant_id +: 8];
      y_q   <= bus.req_y[8*grant_id +: 8];
      op_q  <= bus.req_op[4*grant_id +: 4];
      cin_q <= bus.req_cin[grant_id];
      id_q  <= grant_id;
    end
  end

  // Register the ALU result in EXEC; it then holds through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
    end else if (state_q == EXEC) begin
      rsp_data_q  <= alu_res;
      rsp_carry_q <= alu_carry;
      rsp_id_q    <= id_q;
    end
  end

  // Count completed response handshakes; wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (rsp_fire) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. Grants are predicted by a round-robin
// reference; each grant pushes the expected response to a scoreboard that
// is popped on every response handshake.
module tb_alu_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     data;
    logic           carry;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.N_REQ(N), .IDW(IDW)) bus ();
  alu_arbiter #(.N_REQ(N), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Per-requester stimulus
  logic [N-1:0] valid;
  logic [7:0]   xa [N];
  logic [7:0]   ya [N];
  logic [3:0]   opa [N];
  logic [N-1:0] cina;
  logic         rsp_rdy;

  always_comb begin
    bus.req_valid = valid;
    bus.req_cin   = cina;
    bus.rsp_ready = rsp_rdy;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_op    = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_x[8*i +: 8]  = xa[i];
      bus.req_y[8*i +: 8]  = ya[i];
      bus.req_op[4*i +: 4] = opa[i];
    end
  end

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_grant = 0;
  int   n_rsp = 0;
  int   hs_cyc = 0;
  int   last_model = N - 1;
  int   grant_ids [$];
  int   grant_cyc [$];
  rsp_t sb [$];
  logic       directed = 1'b1;
  logic [7:0] pend_data = '0;
  logic       pend_carry = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU written from the op-code table.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic [3:0] op, input logic cin);
    int a, b, r;
    a = int'(x);
    b = int'(y);
    case (op[2:0])
      3'd0:    r = a + b + int'(cin);
      3'd1:    r = (b == 0) ? a + int'(cin) : a - b + 256 + int'(cin);
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = (~(a & b)) & 255;
      3'd5:    r = a ^ b;
      3'd6:    r = (~(a | b)) & 255;
      default: r = (~a) & 255;
    endcase
    return 9'(r);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Grant and response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    int         exp_id;
    int         gid;
    int         idx;
    logic [8:0] m;
    rsp_t       e;
    if (!rst_n) begin
      sb.delete();
      last_model = N - 1;
    end else begin
      if (bus.req_ready != '0) begin
        exp_id = -1;
        gid    = -1;
        for (int k = 1; k <= N; k++) begin
          idx = (last_model + k) % N;
          if (exp_id < 0 && valid[idx]) exp_id = idx;
        end
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) gid = i;
        check("grant_onehot", $countones(bus.req_ready), 1);
        check("grant_id", gid, exp_id);
        if (directed) begin
          e = '{id: IDW'(gid), data: pend_data, carry: pend_carry};
        end else begin
          m = model(xa[gid], ya[gid], opa[gid], cina[gid]);
          e = '{id: IDW'(gid), data: m[7:0], carry: m[8]};
        end
        sb.push_back(e);
        last_model = gid;
        n_grant++;
        grant_ids.push_back(gid);
        grant_cyc.push_back(cyc);
      end
      if (bus.rsp_valid && rsp_rdy) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", bus.rsp_id, e.id);
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_carry", bus.rsp_carry, e.carry);
        end
        n_rsp++;
        hs_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target, input string tag);
    int t = 0;
    while (n_grant < target && t < 60) begin
      tick();
      t++;
    end
    if (n_grant < target) check(tag, n_grant, target);
  endtask

  task automatic wait_rsps(input int target, input string tag);
    int t = 0;
    while (n_rsp < target && t < 60) begin
      tick();
      t++;
    end
    if (n_rsp < target) check(tag, n_rsp, target);
  endtask

  task automatic wait_rsp_valid(input string tag);
    int t = 0;
    while (!bus.rsp_valid && t < 20) begin
      tick();
      t++;
    end
    if (!bus.rsp_valid) check(tag, 0, 1);
  endtask

  // One isolated operation with a directed expected result.
  task automatic issue(input int id, input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] op, input logic cin,
                       input logic [7:0] ed, input logic ec);
    int g, r;
    g = n_grant + 1;
    r = n_rsp + 1;
    xa[id] = x; ya[id] = y; opa[id] = op; cina[id] = cin;
    pend_data = ed; pend_carry = ec; directed = 1'b1;
    valid[id] = 1'b1;
    wait_grants(g, "issue_grant_timeout");
    valid[id] = 1'b0;
    wait_rsps(r, "issue_rsp_timeout");
  endtask

  initial begin
    int g0, r0, g;
    valid = '0; cina = '0; rsp_rdy = 1'b1; rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      xa[i] = '0; ya[i] = '0; opa[i] = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_op_count", bus.op_count, 0);

    // Reset asserted while an operation sits in EXEC.
    tick();
    xa[0] = 8'h12; ya[0] = 8'h34; opa[0] = 4'h0; cina[0] = 1'b0;
    pend_data = 8'h46; pend_carry = 1'b0;
    valid[0] = 1'b1;
    wait_grants(1, "pre_reset_grant_timeout");
    valid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midexec_rsp_valid", bus.rsp_valid, 0);
    check("midexec_req_ready", bus.req_ready, 0);
    check("midexec_op_count", bus.op_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    r0 = n_rsp;
    repeat (6) tick();
    check("no_rsp_after_reset", n_rsp, r0);

    // Round robin with all requesters valid.
    xa[0] = 8'h4F; ya[0] = 8'hA5; opa[0] = 4'h0; cina[0] = 1'b0;
    xa[1] = 8'hFF; ya[1] = 8'h01; opa[1] = 4'h1; cina[1] = 1'b1;
    xa[2] = 8'h3C; ya[2] = 8'h0F; opa[2] = 4'h3; cina[2] = 1'b0;
    xa[3] = 8'h80; ya[3] = 8'h80; opa[3] = 4'h0; cina[3] = 1'b1;
    directed = 1'b0;
    g0 = n_grant;
    r0 = n_rsp;
    valid = '1;
    wait_grants(g0 + 5, "rr_grant_timeout");
    valid = '0;
    wait_rsps(r0 + 5, "rr_rsp_timeout");
    if (grant_ids.size() >= g0 + 5) begin
      for (int k = 0; k < 5; k++) check("rr_order", grant_ids[g0 + k], k % N);
      for (int k = 1; k < 5; k++)
        check("rr_spacing", grant_cyc[g0 + k] - grant_cyc[g0 + k - 1], 3);
    end
    @(negedge clk);
    check("rr_op_count", bus.op_count, 5);
    tick();

    // Arithmetic from requester 1.
    issue(1, 8'h4F, 8'hA5, 4'h0, 1'b0, 8'hF4, 1'b0);
    issue(1, 8'h4F, 8'hA5, 4'h1, 1'b0, 8'hAA, 1'b0);
    issue(1, 8'hFF, 8'h01, 4'h0, 1'b0, 8'h00, 1'b1);
    issue(1, 8'h05, 8'h03, 4'h1, 1'b0, 8'h02, 1'b1);
    issue(1, 8'hFF, 8'h00, 4'h1, 1'b1, 8'h00, 1'b1);
    issue(1, 8'h37, 8'h00, 4'h1, 1'b0, 8'h37, 1'b0);
    // Logic ops and op[3] aliasing.
    issue(1, 8'h4F, 8'hA5, 4'h2, 1'b0, 8'h05, 1'b0);
    issue(1, 8'h4F, 8'hA5, 4'h5, 1'b0, 8'hEA, 1'b0);
    issue(1, 8'h4F, 8'hA5, 4'h7, 1'b1, 8'hB0, 1'b0);
    issue(1, 8'h4F, 8'hA5, 4'hD, 1'b0, 8'hEA, 1'b0);
    issue(1, 8'h4F, 8'hA5, 4'h4, 1'b1, 8'hFA, 1'b0);
    issue(1, 8'h4F, 8'hA5, 4'hE, 1'b0, 8'h10, 1'b0);

    // Backpressure with requester 2 kept valid.
    rsp_rdy = 1'b0;
    xa[2] = 8'h4F; ya[2] = 8'hA5; opa[2] = 4'h0; cina[2] = 1'b0;
    pend_data = 8'hF4; pend_carry = 1'b0; directed = 1'b1;
    g = n_grant + 1;
    r0 = n_rsp;
    valid[2] = 1'b1;
    wait_grants(g, "bp_grant_timeout");
    opa[2] = 4'h5;
    pend_data = 8'hEA;
    wait_rsp_valid("bp_rsp_valid_timeout");
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_data", bus.rsp_data, 8'hF4);
      check("bp_rsp_id", bus.rsp_id, 2);
      check("bp_req_ready", bus.req_ready, 0);
    end
    tick();
    rsp_rdy = 1'b1;
    wait_grants(g + 1, "bp_regrant_timeout");
    check("bp_one_handshake", n_rsp, r0 + 1);
    if (grant_cyc.size() > 0) check("bp_regrant_cycle", grant_cyc[$] - hs_cyc, 1);
    valid[2] = 1'b0;
    wait_rsps(r0 + 2, "bp_rsp2_timeout");

    // Sparse request plus a withdrawn one during RESP.
    rsp_rdy = 1'b0;
    xa[3] = 8'h05; ya[3] = 8'h03; opa[3] = 4'h1; cina[3] = 1'b0;
    pend_data = 8'h02; pend_carry = 1'b1;
    g = n_grant;
    r0 = n_rsp;
    valid[3] = 1'b1;
    wait_grants(g + 1, "sparse_grant_timeout");
    valid[3] = 1'b0;
    if (grant_ids.size() > 0) check("sparse_id", grant_ids[$], 3);
    wait_rsp_valid("sparse_rsp_valid_timeout");
    valid[2] = 1'b1;
    tick();
    valid[2] = 1'b0;
    tick();
    rsp_rdy = 1'b1;
    repeat (8) tick();
    check("withdrawn_rsp_count", n_rsp, r0 + 1);
    check("withdrawn_grant_count", n_grant, g + 1);

    @(negedge clk);
    check("final_op_count", bus.op_count, 16'(n_rsp));
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
